// File: rtl/softex_tcdm_responder_pkg.sv
// Shared constants and helpers for the TCDM responder: stall LFSR seed and step function.
// The LFSR is a right-shifting Fibonacci register with taps 16,14,13,11.
package softex_tcdm_responder_pkg;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Taps 16,14,13,11 land on bit positions 0,2,3,5 of a right-shifting register.
  localparam int LFSR_TAP0 = 0;
  localparam int LFSR_TAP1 = 2;
  localparam int LFSR_TAP2 = 3;
  localparam int LFSR_TAP3 = 5;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[LFSR_TAP0] ^ s[LFSR_TAP1] ^ s[LFSR_TAP2] ^ s[LFSR_TAP3];
    return {fb, s[15:1]};
  endfunction

endpackage

// File: rtl/softex_tcdm_responder_rsp_fifo.sv
// Per-port response FIFO; one-cycle push-to-visible, head shown combinationally.
// Pointers carry one extra wrap bit so full and empty are distinguishable without a counter.
module softex_tcdm_responder_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 41
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_dat,
  output logic         o_vld
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_full;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_dat;
  end

  assign o_vld  = (r_wptr != r_rptr);
  assign w_full = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_dat  = r_mem[r_rptr[AW-1:0]];

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(i_push && w_full));

endmodule

// File: rtl/softex_tcdm_responder.sv
// TCDM responder: MP word-interleaved SRAM banks with lowest-index bank arbitration and per-port response FIFOs.
// Reads return LATENCY cycles after grant; r_ready backpressure throttles grants through per-port credits.
module softex_tcdm_responder
  import softex_tcdm_responder_pkg::*;
#(
  parameter int MP         = 8,
  parameter int BANK_WORDS = 1024,
  parameter int LATENCY    = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_en_i,
  input  logic [MP-1:0]      req_i,
  output logic [MP-1:0]      gnt_o,
  input  logic [MP*32-1:0]   add_i,
  input  logic [MP-1:0]      wen_i,
  input  logic [MP*4-1:0]    be_i,
  input  logic [MP*32-1:0]   data_i,
  input  logic [MP-1:0]      r_ready_i,
  input  logic [MP*ID_W-1:0] id_i,
  output logic [MP*32-1:0]   r_data_o,
  output logic [MP-1:0]      r_valid_o,
  output logic [ID_W-1:0]    r_id_o,
  output logic               r_opc_o,
  output logic               r_user_o,
  output logic               addr_err_o
);
  localparam int BK_W  = $clog2(MP);
  localparam int ROW_W = $clog2(BANK_WORDS);
  localparam int CRD_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [31:0]     data;
    logic [ID_W-1:0] id;
    logic            err;
  } tcdm_rsp_t;

  logic [15:0]      r_lfsr;
  logic             r_addr_err;
  logic [31:0]      r_mem [MP][BANK_WORDS];
  logic [BK_W-1:0]  w_bank [MP];
  logic [ROW_W-1:0] w_row [MP];
  logic [MP-1:0]    w_oor;
  logic [MP-1:0]    w_win;
  logic [MP-1:0]    w_gnt;
  logic [MP-1:0]    w_fifo_vld;
  tcdm_rsp_t        w_head [MP];

  // A requester that is itself blocked by credit or stall still shadows higher ports on its bank.
  always_comb begin
    w_win = '1;
    for (int i = 1; i < MP; i++)
      for (int j = 0; j < i; j++)
        if (req_i[j] && (w_bank[j] == w_bank[i])) w_win[i] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lfsr     <= LFSR_SEED;
      r_addr_err <= 1'b0;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
      if (|(w_gnt & w_oor)) r_addr_err <= 1'b1;
    end
  end

  // At most one grant per bank per cycle, so writes never collide.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MP; i++)
      if (w_gnt[i] && !wen_i[i])
        for (int b = 0; b < 4; b++)
          if (be_i[i*4+b]) r_mem[w_bank[i]][w_row[i]][b*8 +: 8] <= data_i[i*32+b*8 +: 8];
  end

  for (genvar i = 0; i < MP; i++) begin : g_port
    logic [CRD_W-1:0] r_credit;
    logic             w_rd_gnt;
    logic             w_pop;
    logic             w_push;
    tcdm_rsp_t        w_rd_rsp;
    tcdm_rsp_t        w_push_rsp;

    assign w_bank[i] = add_i[i*32+2 +: BK_W];
    assign w_row[i]  = add_i[i*32+2+BK_W +: ROW_W];
    assign w_oor[i]  = (add_i[i*32 +: 32] >> (2 + BK_W + ROW_W)) != 32'd0;

    assign w_gnt[i] = ~rst_i & req_i[i] & w_win[i] & (r_credit < CRD_W'(FIFO_DEPTH))
                    & ~(stall_en_i & r_lfsr[i % 16]);
    assign w_rd_gnt = w_gnt[i] & wen_i[i];
    assign w_pop    = w_fifo_vld[i] & r_ready_i[i];

    assign w_rd_rsp.data = r_mem[w_bank[i]][w_row[i]];
    assign w_rd_rsp.id   = id_i[i*ID_W +: ID_W];
    assign w_rd_rsp.err  = w_oor[i];

    if (LATENCY == 1) begin : g_nopipe
      assign w_push     = w_rd_gnt;
      assign w_push_rsp = w_rd_rsp;
    end else begin : g_pipe
      logic [LATENCY-2:0] r_pv;
      tcdm_rsp_t          r_pd [LATENCY-1];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_pv <= '0;
        end else begin
          r_pv[0] <= w_rd_gnt;
          for (int k = 1; k < LATENCY - 1; k++) r_pv[k] <= r_pv[k-1];
        end
      end

      always_ff @(posedge clk_i) begin
        r_pd[0] <= w_rd_rsp;
        for (int k = 1; k < LATENCY - 1; k++) r_pd[k] <= r_pd[k-1];
      end

      assign w_push     = r_pv[LATENCY-2];
      assign w_push_rsp = r_pd[LATENCY-2];
    end

    // Credit covers FIFO entries plus reads still in the pipe.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_credit <= '0;
      end else begin
        case ({w_rd_gnt, w_pop})
          2'b10:   r_credit <= r_credit + 1'b1;
          2'b01:   r_credit <= r_credit - 1'b1;
          default: r_credit <= r_credit;
        endcase
      end
    end

    softex_tcdm_responder_rsp_fifo #(
      .DEPTH(FIFO_DEPTH),
      .W    ($bits(tcdm_rsp_t))
    ) u_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .i_push(w_push),
      .i_dat (w_push_rsp),
      .i_pop (w_pop),
      .o_dat (w_head[i]),
      .o_vld (w_fifo_vld[i])
    );

    assign r_valid_o[i]          = w_fifo_vld[i];
    assign r_data_o[i*32 +: 32]  = w_fifo_vld[i] ? w_head[i].data : 32'd0;

    a_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (r_valid_o[i] && !r_ready_i[i]) |=> $stable(r_data_o[i*32 +: 32]));
  end

  assign gnt_o      = w_gnt;
  assign r_id_o     = w_fifo_vld[0] ? w_head[0].id : '0;
  assign r_opc_o    = w_fifo_vld[0] & w_head[0].err;
  assign r_user_o   = 1'b0;
  assign addr_err_o = r_addr_err;

endmodule

// File: tb/tb_softex_tcdm_responder.sv
// Bench for softex_tcdm_responder: directed scenarios plus a randomized burst, all checked
// every cycle against a queue-based model of memory, arbitration, credits and response timing.
module tb_softex_tcdm_responder;
  localparam int MP         = 8;
  localparam int BANK_WORDS = 1024;
  localparam int LATENCY    = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int ID_W       = 8;
  localparam int NWORDS     = MP * BANK_WORDS;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               stall_en = 1'b0;
  logic [MP-1:0]      req = '0;
  logic [MP-1:0]      wen = '0;
  logic [MP-1:0]      r_ready = '0;
  logic [MP*32-1:0]   add = '0;
  logic [MP*32-1:0]   wdata = '0;
  logic [MP*4-1:0]    be = '0;
  logic [MP*ID_W-1:0] id = '0;
  logic [MP-1:0]      gnt_o;
  logic [MP*32-1:0]   r_data_o;
  logic [MP-1:0]      r_valid_o;
  logic [ID_W-1:0]    r_id_o;
  logic               r_opc_o;
  logic               r_user_o;
  logic               addr_err_o;

  always #5 clk = ~clk;

  softex_tcdm_responder #(
    .MP(MP), .BANK_WORDS(BANK_WORDS), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH), .ID_W(ID_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .stall_en_i(stall_en), .req_i(req), .gnt_o(gnt_o),
    .add_i(add), .wen_i(wen), .be_i(be), .data_i(wdata), .r_ready_i(r_ready), .id_i(id),
    .r_data_o(r_data_o), .r_valid_o(r_valid_o), .r_id_o(r_id_o), .r_opc_o(r_opc_o),
    .r_user_o(r_user_o), .addr_err_o(addr_err_o)
  );

  // Reference model: each port owns an ordered list of pending responses tagged with the
  // cycle they become visible; its length is the port's outstanding count.
  typedef struct {
    logic [31:0]     d;
    logic [ID_W-1:0] id;
    bit              err;
    int              due;
  } exp_t;

  exp_t        mq [MP][$];
  bit   [31:0] m_mem [int];
  bit   [15:0] m_lfsr = 16'hACE1;
  bit          m_err = 1'b0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_on = 1'b0;

  function automatic logic [31:0] addr_of(int p);
    return add[p*32 +: 32];
  endfunction

  function automatic int word_of(int p);
    return int'((addr_of(p) >> 2) % NWORDS);
  endfunction

  function automatic bit oor_of(int p);
    return addr_of(p) >= 32'(NWORDS * 4);
  endfunction

  function automatic logic [MP-1:0] exp_gnt();
    logic [MP-1:0] g;
    g = '0;
    if (rst) return g;
    for (int i = 0; i < MP; i++) begin
      bit ok;
      ok = req[i];
      for (int j = 0; j < i; j++)
        if (req[j] && (word_of(j) % MP) == (word_of(i) % MP)) ok = 1'b0;
      if (mq[i].size() >= FIFO_DEPTH) ok = 1'b0;
      if (stall_en && m_lfsr[i % 16]) ok = 1'b0;
      g[i] = ok;
    end
    return g;
  endfunction

  function automatic logic [MP-1:0] exp_vld();
    logic [MP-1:0] v;
    v = '0;
    if (rst) return v;
    for (int i = 0; i < MP; i++)
      v[i] = (mq[i].size() > 0) && (mq[i][0].due <= cyc);
    return v;
  endfunction

  task automatic model_step();
    logic [MP-1:0] g;
    logic [MP-1:0] v;
    bit   [31:0]   nw;
    bit            fb;
    exp_t          e;
    if (rst) begin
      for (int i = 0; i < MP; i++) mq[i].delete();
      m_lfsr = 16'hACE1;
      m_err  = 1'b0;
    end else begin
      g = exp_gnt();
      v = exp_vld();
      for (int i = 0; i < MP; i++)
        if (v[i] && r_ready[i]) void'(mq[i].pop_front());
      for (int i = 0; i < MP; i++) begin
        if (!g[i]) continue;
        if (oor_of(i)) m_err = 1'b1;
        if (wen[i]) begin
          e.d   = m_mem.exists(word_of(i)) ? m_mem[word_of(i)] : 32'hDEAD_BEEF;
          e.id  = id[i*ID_W +: ID_W];
          e.err = oor_of(i);
          e.due = cyc + LATENCY;
          mq[i].push_back(e);
        end else begin
          nw = m_mem.exists(word_of(i)) ? m_mem[word_of(i)] : 32'd0;
          for (int b = 0; b < 4; b++)
            if (be[i*4+b]) nw[b*8 +: 8] = wdata[i*32+b*8 +: 8];
          m_mem[word_of(i)] = nw;
        end
      end
      fb = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
      m_lfsr = (m_lfsr >> 1) | (16'(fb) << 15);
    end
    cyc++;
  endtask

  always @(posedge clk) model_step();

  task automatic chk(string nm, logic [63:0] act, logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      logic [MP-1:0] v;
      v = exp_vld();
      chk("gnt", gnt_o, exp_gnt());
      chk("r_valid", r_valid_o, v);
      chk("addr_err", addr_err_o, rst ? 1'b0 : m_err);
      chk("r_user", r_user_o, 1'b0);
      for (int i = 0; i < MP; i++)
        if (v[i]) chk($sformatf("r_data[%0d]", i), r_data_o[i*32 +: 32], mq[i][0].d);
      if (v[0]) begin
        chk("r_id", r_id_o, mq[0][0].id);
        chk("r_opc", r_opc_o, mq[0][0].err);
      end
    end
  end

  task automatic set_port(int p, bit rd, logic [31:0] a, logic [31:0] d, logic [3:0] b,
                          logic [ID_W-1:0] tid);
    req[p] = 1'b1;
    wen[p] = rd;
    add[p*32 +: 32] = a;
    wdata[p*32 +: 32] = d;
    be[p*4 +: 4] = b;
    id[p*ID_W +: ID_W] = tid;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ngnt;
    r_ready = '1;
    repeat (2) @(posedge clk);
    #1;
    chk_on = 1'b1;

    // Reset state with requests pending: nothing granted or returned.
    req = '1;
    wen = '1;
    @(negedge clk);
    chk("rst_gnt", gnt_o, '0);
    chk("rst_vld", r_valid_o, '0);
    chk("rst_data", r_data_o, '0);
    chk("rst_id", r_id_o, '0);
    chk("rst_opc", r_opc_o, 1'b0);
    chk("rst_err", addr_err_o, 1'b0);
    next_cycle();
    rst = 1'b0;
    req = '0;

    // 1: full-width write then read back.
    for (int i = 0; i < MP; i++)
      set_port(i, 1'b0, 32'h1000 + 32'(4 * i), 32'(i) * 32'h1111_1111, 4'hF, '0);
    @(negedge clk);
    chk("t1_wr_gnt", gnt_o, 8'hFF);
    next_cycle();
    for (int i = 0; i < MP; i++)
      set_port(i, 1'b1, 32'h1000 + 32'(4 * i), 32'd0, 4'h0, 8'h10 + 8'(i));
    @(negedge clk);
    chk("t1_rd_gnt", gnt_o, 8'hFF);
    next_cycle();
    req = '0;
    @(negedge clk);
    chk("t1_vld", r_valid_o, 8'hFF);
    for (int i = 0; i < MP; i++)
      chk("t1_data", r_data_o[i*32 +: 32], 32'(i) * 32'h1111_1111);
    chk("t1_id", r_id_o, 8'h10);
    next_cycle();

    // Preload words 0..63 with a recognisable pattern.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < MP; i++)
        set_port(i, 1'b0, 32'((k * 8 + i) * 4), 32'hC0DE_0000 + 32'(k * 8 + i), 4'hF, '0);
      @(negedge clk);
      next_cycle();
    end
    req = '0;

    // 2: bank conflict, lower port first.
    set_port(0, 1'b1, 32'h20, 32'd0, 4'h0, 8'h20);
    set_port(3, 1'b1, 32'h20, 32'd0, 4'h0, 8'h23);
    @(negedge clk);
    chk("t2_gnt_first", gnt_o, 8'h01);
    next_cycle();
    req[0] = 1'b0;
    @(negedge clk);
    chk("t2_gnt_second", gnt_o, 8'h08);
    next_cycle();
    req = '0;
    @(negedge clk);
    chk("t2_data3", r_data_o[3*32 +: 32], 32'hC0DE_0008);
    next_cycle();

    // 3: partial byte-enable write.
    set_port(0, 1'b0, 32'h40, 32'hFFFF_FFFF, 4'hF, '0);
    @(negedge clk);
    next_cycle();
    set_port(0, 1'b0, 32'h40, 32'hAABB_CCDD, 4'b0101, '0);
    @(negedge clk);
    next_cycle();
    set_port(0, 1'b1, 32'h40, 32'd0, 4'h0, 8'h33);
    @(negedge clk);
    next_cycle();
    req = '0;
    @(negedge clk);
    chk("t3_vld", r_valid_o[0], 1'b1);
    chk("t3_data", r_data_o[31:0], 32'hFFBB_FFDD);
    next_cycle();

    // 4: backpressure caps outstanding reads at the FIFO depth.
    r_ready = '0;
    ngnt = 0;
    for (int k = 0; k < 6; k++) begin
      set_port(0, 1'b1, 32'h0, 32'd0, 4'h0, 8'h40 + 8'(ngnt));
      @(negedge clk);
      if (gnt_o[0]) ngnt++;
      next_cycle();
    end
    chk("t4_ngnt", 64'(ngnt), 64'd4);
    req = '0;
    r_ready = '1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_vld", r_valid_o[0], 1'b1);
      chk("t4_id", r_id_o, 8'h40 + 8'(k));
      next_cycle();
    end
    set_port(0, 1'b1, 32'h0, 32'd0, 4'h0, 8'h50);
    @(negedge clk);
    chk("t4_resume", gnt_o[0], 1'b1);
    next_cycle();
    req = '0;
    @(negedge clk);
    next_cycle();

    // 5: out-of-range read aliases to word 0 and sets the sticky error.
    set_port(0, 1'b1, 32'h8000, 32'd0, 4'h0, 8'h55);
    @(negedge clk);
    chk("t5_err_before", addr_err_o, 1'b0);
    next_cycle();
    req = '0;
    @(negedge clk);
    chk("t5_opc", r_opc_o, 1'b1);
    chk("t5_data", r_data_o[31:0], 32'hC0DE_0000);
    chk("t5_err", addr_err_o, 1'b1);
    next_cycle();
    repeat (3) begin
      @(negedge clk);
      next_cycle();
    end
    @(negedge clk);
    chk("t5_sticky", addr_err_o, 1'b1);
    next_cycle();

    // 6: random traffic with grant stalls and a reset in the middle.
    stall_en = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      rst = (n >= 500) && (n < 502);
      req = MP'($urandom);
      r_ready = MP'($urandom | $urandom);
      for (int i = 0; i < MP; i++) begin
        logic [31:0] a;
        a = 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) a = a + 32'h8000 * 32'($urandom_range(1, 65535));
        wen[i] = ($urandom_range(0, 3) != 0);
        add[i*32 +: 32] = a;
        wdata[i*32 +: 32] = $urandom;
        be[i*4 +: 4] = 4'($urandom);
        id[i*ID_W +: ID_W] = ID_W'($urandom);
      end
      @(negedge clk);
      if (n == 500) begin
        chk("t6_rst_vld", r_valid_o, '0);
        chk("t6_rst_gnt", gnt_o, '0);
      end
      next_cycle();
    end
    rst = 1'b0;
    stall_en = 1'b0;
    req = '0;
    r_ready = '1;
    repeat (8) begin
      @(negedge clk);
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
